// File: rtl/user_obi_mgr_arbiter.sv
// Round-robin arbiter sharing one OBI manager port among NumReq requesters.
// One outstanding transaction; the response is routed back to its owner.
package user_obi_mgr_pkg;
  localparam int unsigned ObiAddrWidth = 32;
  localparam int unsigned ObiDataWidth = 32;
  localparam int unsigned ObiIdWidth   = 1;

  typedef struct packed {
    logic [ObiAddrWidth-1:0]   addr;
    logic                      we;
    logic [ObiDataWidth/8-1:0] be;
    logic [ObiDataWidth-1:0]   wdata;
    logic [ObiIdWidth-1:0]     aid;
  } obi_a_chan_t;

  typedef struct packed {
    logic        req;
    obi_a_chan_t a;
  } obi_req_t;

  typedef struct packed {
    logic [ObiDataWidth-1:0] rdata;
    logic                    err;
  } obi_r_chan_t;

  typedef struct packed {
    logic        gnt;
    logic        rvalid;
    obi_r_chan_t r;
  } obi_rsp_t;
endpackage

module user_obi_mgr_arbiter
  import user_obi_mgr_pkg::*;
#(
  parameter int unsigned NumReq    = 2,
  parameter int unsigned AddrWidth = ObiAddrWidth,
  parameter int unsigned DataWidth = ObiDataWidth,
  parameter type mgr_obi_req_t     = obi_req_t,
  parameter type mgr_obi_rsp_t     = obi_rsp_t
) (
  input  logic                                clk_i,
  input  logic                                rst_ni,
  input  logic [NumReq-1:0]                   req_i,
  input  logic [NumReq-1:0]                   we_i,
  input  logic [NumReq-1:0][AddrWidth-1:0]    addr_i,
  input  logic [NumReq-1:0][DataWidth/8-1:0]  be_i,
  input  logic [NumReq-1:0][DataWidth-1:0]    wdata_i,
  output logic [NumReq-1:0]                   gnt_o,
  output logic [NumReq-1:0]                   rvalid_o,
  output logic [DataWidth-1:0]                rdata_o,
  output logic                                err_o,
  output mgr_obi_req_t                        obi_mgr_req_o,
  input  mgr_obi_rsp_t                        obi_mgr_rsp_i
);

  localparam int unsigned IdxW = $clog2(NumReq);

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StAddr = 2'd1;
  localparam logic [1:0] StResp = 2'd2;

  logic [1:0]             state_q, state_d;
  logic [IdxW-1:0]        owner_q, owner_d;
  logic [IdxW-1:0]        rr_q, rr_d;
  logic [IdxW-1:0]        sel_idx;
  logic                   we_q, we_d;
  logic [AddrWidth-1:0]   addr_q, addr_d;
  logic [DataWidth/8-1:0] be_q, be_d;
  logic [DataWidth-1:0]   wdata_q, wdata_d;

  // First requester at or after the rr pointer, wrapping.
  always_comb begin : pick
    logic            found;
    int unsigned     idx;
    logic [IdxW-1:0] cand;
    found   = 1'b0;
    idx     = 0;
    cand    = '0;
    sel_idx = rr_q;
    for (int unsigned i = 0; i < NumReq; i++) begin
      idx = 32'(rr_q) + i;
      if (idx >= NumReq) idx = idx - NumReq;
      cand = IdxW'(idx);
      if (!found && req_i[cand]) begin
        found   = 1'b1;
        sel_idx = cand;
      end
    end
  end

  always_comb begin : fsm
    state_d  = state_q;
    owner_d  = owner_q;
    rr_d     = rr_q;
    we_d     = we_q;
    addr_d   = addr_q;
    be_d     = be_q;
    wdata_d  = wdata_q;
    gnt_o    = '0;
    rvalid_o = '0;
    rdata_o  = '0;
    err_o    = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (|req_i) begin
          owner_d = sel_idx;
          we_d    = we_i[sel_idx];
          addr_d  = addr_i[sel_idx];
          be_d    = be_i[sel_idx];
          wdata_d = wdata_i[sel_idx];
          state_d = StAddr;
        end
      end
      StAddr: begin
        if (obi_mgr_rsp_i.gnt) begin
          gnt_o[owner_q] = 1'b1;
          rr_d = (owner_q == IdxW'(NumReq - 1)) ? '0 : owner_q + 1'b1;
          state_d = StResp;
        end
      end
      StResp: begin
        if (obi_mgr_rsp_i.rvalid) begin
          rvalid_o[owner_q] = 1'b1;
          rdata_o = obi_mgr_rsp_i.r.rdata;
          err_o   = obi_mgr_rsp_i.r.err;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin : obi_out
    obi_mgr_req_o         = '0;
    obi_mgr_req_o.req     = (state_q == StAddr);
    obi_mgr_req_o.a.addr  = addr_q;
    obi_mgr_req_o.a.we    = we_q;
    obi_mgr_req_o.a.be    = be_q;
    obi_mgr_req_o.a.wdata = wdata_q;
    obi_mgr_req_o.a.aid   = '0;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= StIdle;
      owner_q <= '0;
      rr_q    <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      be_q    <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      rr_q    <= rr_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      be_q    <= be_d;
      wdata_q <= wdata_d;
    end
  end

endmodule
